// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_sweep_pkg
//  Purpose  : Shared types and helpers for the 5-input gate sweep controller.
//             - state_e : sweep FSM states
//             - mode_e  : expected-function codes (AND/OR/NAND/NOR)
//             - exp_out : expected gate output for a vector under a mode
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package gate_sweep_pkg;

  // Widest gate the expected-output helper can evaluate.
  localparam int unsigned MAX_N_IN = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_NAND = 2'b10,
    MODE_NOR  = 2'b11
  } mode_e;

  // Only the low n bits of vec take part in the reduction, so one helper
  // serves any gate width up to MAX_N_IN.
  function automatic logic exp_out(input logic [MAX_N_IN-1:0] vec,
                                   input int unsigned         n,
                                   input mode_e               mode);
    logic all1;
    logic any1;
    logic res;
    all1 = 1'b1;
    any1 = 1'b0;
    for (int unsigned i = 0; i < MAX_N_IN; i++) begin
      if (i < n) begin
        all1 = all1 & vec[i];
        any1 = any1 | vec[i];
      end
    end
    case (mode)
      MODE_AND:  res = all1;
      MODE_OR:   res = any1;
      MODE_NAND: res = ~all1;
      MODE_NOR:  res = ~any1;
      default:   res = all1;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sweep_expect.sv
`default_nettype none
// ============================================================================
//  Module   : gate_sweep_expect
//  Purpose  : Combinational expected-output model of the gate under test.
//  Ports    : vec_i  [N_IN-1:0]  stimulus vector currently on the gate
//             mode_i [1:0]       expected function code (mode_e)
//             exp_o              expected gate output
//  Revision : 1.0  initial release
// ============================================================================
module gate_sweep_expect
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 5
) (
  input  logic [N_IN-1:0] vec_i,
  input  logic [1:0]      mode_i,
  output logic            exp_o
);

  logic [MAX_N_IN-1:0] vec_ext;

  assign vec_ext = MAX_N_IN'(vec_i);
  assign exp_o   = exp_out(vec_ext, N_IN, mode_e'(mode_i));

endmodule
`default_nettype wire

// File: rtl/gate5_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gate5_sweep_ctrl
//  Purpose  : Exhaustive stimulus sequencer and checker for one N_IN-input
//             gate. Walks every vector 0..2**N_IN-1, holds each for
//             SETTLE_CYC cycles, samples the gate output once and counts
//             mismatches against the expected function.
//  Ports    : clk, rst          clock / synchronous active-high reset
//             start, abort      sweep control pulses (abort wins)
//             mode [1:0]        expected function, latched at start
//             vec_o [N_IN-1:0]  stimulus to gate inputs
//             dut_o             gate output under test
//             busy, done, pass  sweep status
//             err_cnt [ERR_W-1:0] saturating mismatch count
//             first_fail_vec/_vld  first mismatching vector of the sweep
//  Revision : 1.0  initial release
// ============================================================================
module gate5_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = 5,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned ERR_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  vec_o,
  input  logic             dut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_vld
);

  // Settle counter runs 0..SETTLE_CYC-1.
  localparam int unsigned      CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  VEC_LAST   = '1;
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [N_IN-1:0]  vec_q,    vec_d;
  mode_e            mode_q,   mode_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             pass_q,   pass_d;
  logic [ERR_W-1:0] err_q,    err_d;
  logic [N_IN-1:0]  ffv_q,    ffv_d;
  logic             ffvld_q,  ffvld_d;

  logic exp_bit;
  logic mismatch;

  gate_sweep_expect #(
    .N_IN (N_IN)
  ) u_expect (
    .vec_i  (vec_q),
    .mode_i (mode_q),
    .exp_o  (exp_bit)
  );

  assign mismatch = (dut_o != exp_bit);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvld_d  = ffvld_q;

    case (state_q)
      IDLE, DONE: begin
        // Abort has priority: a coincident start is dropped.
        if (start && !abort) begin
          mode_d   = mode_e'(mode);
          err_d    = '0;
          ffv_d    = '0;
          ffvld_d  = 1'b0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          vec_d    = '0;
          busy_d   = 1'b1;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          vec_d    = '0;
          settle_d = '0;
        end else if (settle_q == SETTLE_END) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end

      SAMPLE: begin
        // An abort landing on the sample cycle discards that sample;
        // error/capture registers keep what the earlier vectors produced.
        if (abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          vec_d    = '0;
          settle_d = '0;
        end else begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!ffvld_q) begin
              ffv_d   = vec_q;
              ffvld_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Includes the compare just made on the last vector.
            pass_d  = (err_q == '0) && !mismatch;
          end else begin
            vec_d    = vec_q + N_IN'(1);
            settle_d = '0;
            state_d  = SETTLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      vec_q    <= '0;
      mode_q   <= MODE_AND;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ffv_q    <= '0;
      ffvld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvld_q  <= ffvld_d;
    end
  end

  assign vec_o          = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffvld_q;

endmodule
`default_nettype wire

// File: tb/tb_gate5_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate5_sweep_ctrl
//  Purpose  : Self-checking bench for gate5_sweep_ctrl (default parameters)
//             plus a second instance with a 3-bit error counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gate5_sweep_ctrl;

  localparam int SWEEP_CYC = 32 * (4 + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [1:0] mode;
  logic [4:0] vec_o;
  logic       dut_o;
  logic       busy, done, pass;
  logic [5:0] err_cnt;
  logic [4:0] ffv;
  logic       ffvld;

  logic       start3, abort3;
  logic [1:0] mode3;
  logic [4:0] vec3;
  logic       dut3_o;
  logic       busy3, done3, pass3;
  logic [2:0] err3;
  logic [4:0] ffv3;
  logic       ffvld3;

  // Gate under test: 0 real AND5, 1 stuck-at-0, 2 arbitrary truth table.
  int          gate_kind;
  logic [31:0] tbl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (gate_kind)
      0:       dut_o = &vec_o;
      1:       dut_o = 1'b0;
      2:       dut_o = tbl[vec_o];
      default: dut_o = 1'b0;
    endcase
  end

  assign dut3_o = 1'b0;

  gate5_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .vec_o(vec_o), .dut_o(dut_o), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail_vec(ffv), .first_fail_vld(ffvld)
  );

  gate5_sweep_ctrl #(.N_IN(5), .SETTLE_CYC(4), .ERR_W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .mode(mode3),
    .vec_o(vec3), .dut_o(dut3_o), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .first_fail_vec(ffv3), .first_fail_vld(ffvld3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk all 32 vectors with the plain-language truth of each mode.
  task automatic model(input logic [1:0] m, input int kind, input logic [31:0] t,
                       input int cap, output int e, output int fv, output int vld,
                       output int p);
    int  raw;
    bit  want, got;
    raw = 0; fv = 0; vld = 0;
    for (int v = 0; v < 32; v++) begin
      case (m)
        2'b00:   want = (v == 31);
        2'b01:   want = (v != 0);
        2'b10:   want = (v != 31);
        default: want = (v == 0);
      endcase
      case (kind)
        0:       got = (v == 31);
        1:       got = 1'b0;
        default: got = t[v];
      endcase
      if (want != got) begin
        if (vld == 0) begin
          fv  = v;
          vld = 1;
        end
        raw++;
      end
    end
    e = (raw > cap) ? cap : raw;
    p = (raw == 0) ? 1 : 0;
  endtask

  // Full sweep on the default instance; optional start pokes while busy and
  // random mode churn verify both are ignored mid-run.
  task automatic run_sweep(input string tag, input logic [1:0] m, input int kind,
                           input logic [31:0] t, input bit pokes);
    int cycles, e, fv, vld, p;
    bit seq_bad;
    model(m, kind, t, 63, e, fv, vld, p);
    @(negedge clk);
    mode = m; gate_kind = kind; tbl = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr"}, {28'd0, done, pass, |err_cnt, ffvld}, 32'd0);
    cycles  = 0;
    seq_bad = 1'b0;
    while (busy === 1'b1 && cycles < 1000) begin
      cycles++;
      if (vec_o !== 5'((cycles - 1) / 5)) seq_bad = 1'b1;
      start = pokes && (cycles == 30 || cycles == 77);
      if (pokes) mode = 2'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_cycles"}, cycles, SWEEP_CYC);
    check({tag, "_vecseq"}, seq_bad, 0);
    check({tag, "_done"},   {done, busy}, 2'b10);
    check({tag, "_pass"},   pass, p);
    check({tag, "_errcnt"}, err_cnt, e);
    check({tag, "_ffvld"},  ffvld, vld);
    check({tag, "_ffvec"},  ffv, fv);
  endtask

  initial begin
    int e, fv, vld, p, cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
    start3 = 1'b0; abort3 = 1'b0; mode3 = 2'b01;
    gate_kind = 0; tbl = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outs",  {busy, done, pass, err_cnt, ffv, ffvld, vec_o}, 32'd0);
    check("reset_outs3", {busy3, done3, pass3, err3, ffv3, ffvld3, vec3}, 32'd0);

    // 1: AND mode against a real AND5.
    run_sweep("and_ok", 2'b00, 0, '0, 1'b0);
    // 2: OR expected, AND5 fitted.
    run_sweep("or_vs_and", 2'b01, 0, '0, 1'b0);
    // 3: NOR expected, output stuck at 0.
    run_sweep("nor_sa0", 2'b11, 1, '0, 1'b0);

    // abort while DONE: no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_done", {busy, done, err_cnt}, {2'b01, 6'd1});
    // abort + start together while DONE: start dropped.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_start_same", {busy, done, err_cnt}, {2'b01, 6'd1});

    // 4: abort sampled on the 50th edge after the accepting edge. That edge
    // is the sample of vector 9, which is discarded; vectors 1..8 mismatch.
    mode = 2'b01; gate_kind = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_status", {busy, done, pass, vec_o}, 8'd0);
    check("abort_errheld", err_cnt, 8);
    check("abort_ffheld",  {ffvld, ffv}, {1'b1, 5'd1});
    @(negedge clk);
    check("abort_idle", busy, 0);
    run_sweep("after_abort", 2'b00, 0, '0, 1'b0);

    // 5: reset mid-sweep at vector 12.
    mode = 2'b01; gate_kind = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (vec_o !== 5'd12 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("reach_vec12", vec_o, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_sweep", {busy, done, pass, err_cnt, ffv, ffvld, vec_o}, 32'd0);
    @(negedge clk);
    check("rst_stays_idle", {busy, vec_o}, 6'd0);
    run_sweep("start_busy", 2'b00, 0, '0, 1'b1);

    // Randomised expected modes against random truth tables.
    for (int r = 0; r < 4; r++) begin
      run_sweep($sformatf("rand%0d", r), 2'($urandom_range(0, 3)), 2, $urandom, 1'b0);
    end

    // 6: 3-bit error counter saturates.
    model(2'b01, 1, '0, 7, e, fv, vld, p);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cnt = 0;
    while (busy3 === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("sat_cycles", cnt, SWEEP_CYC);
    check("sat_errcnt", err3, e);
    check("sat_ffvec",  {ffvld3, ffv3}, {vld[0], fv[4:0]});
    check("sat_status", {done3, pass3}, {1'b1, p[0]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
